// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR defaults and FSM state encoding
package lfsr_pkg;

  localparam int          LFSR_DEF_WIDTH = 13;
  localparam logic [12:0] LFSR_DEF_TAPS  = 13'h100D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational STEP-fold LFSR advance with shifted-out bits
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] cur_state,
  output logic [WIDTH-1:0] next_state,
  output logic [STEP-1:0]  shift_bits
);

  // apply the single shift STEP times; bit k records what fell off bit 0 on shift k
  always_comb begin
    logic [WIDTH-1:0] s;
    s          = cur_state;
    shift_bits = '0;
    for (int k = 0; k < STEP; k++) begin
      shift_bits[k] = s[0];
      s             = {^(s & TAPS), s[WIDTH-1:1]};
    end
    next_state = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parameterised Fibonacci LFSR with seed load, lockup and period detection
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_DEF_TAPS),
  parameter int               STEP     = 1,
  parameter logic [WIDTH-1:0] SEED_FIX = WIDTH'(1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_load,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_state,
  output logic [STEP-1:0]  o_bits,
  output logic             o_valid,
  output logic             o_seed_fixed,
  output logic             o_lockup,
  output logic             o_period,
  output logic [WIDTH-1:0] o_period_len
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  lfsr_state_e      fsm_q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] adv_state;
  logic [STEP-1:0]  adv_bits;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_next (
    .cur_state  (o_state),
    .next_state (adv_state),
    .shift_bits (adv_bits)
  );

  // advance counter sticks at all-ones instead of wrapping
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + ONE;
  // an all-zero seed would lock the register immediately, so swap in SEED_FIX
  assign load_val = (i_seed == '0) ? SEED_FIX : i_seed;

  // control FSM; load beats advance, every output is registered here
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      fsm_q        <= ST_IDLE;
      o_state      <= '0;
      ref_q        <= '0;
      cnt_q        <= '0;
      o_bits       <= '0;
      o_valid      <= 1'b0;
      o_seed_fixed <= 1'b0;
      o_lockup     <= 1'b0;
      o_period     <= 1'b0;
      o_period_len <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_seed_fixed <= 1'b0;
      o_period     <= 1'b0;
      if (i_load) begin
        fsm_q        <= ST_RUN;
        o_state      <= load_val;
        ref_q        <= load_val;
        cnt_q        <= '0;
        o_lockup     <= 1'b0;
        o_seed_fixed <= (i_seed == '0);
      end else begin
        case (fsm_q)
          ST_RUN: begin
            if (i_en) begin
              o_state <= adv_state;
              o_bits  <= adv_bits;
              o_valid <= 1'b1;
              if (adv_state == ref_q) begin
                o_period     <= 1'b1;
                o_period_len <= cnt_inc;
                cnt_q        <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
              if (adv_state == '0) begin
                fsm_q    <= ST_LOCK;
                o_lockup <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
